// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM/blink stage.
//   ADDR_*        : Avalon-MM register addresses
//   PWM_W         : width of the brightness register and the PWM counter
//   BRIGHT_RESET  : brightness after reset (fully on)
package led_pwm_pkg;
  localparam logic [1:0] ADDR_BRIGHT = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] BRIGHT_RESET = 8'hFF;
endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every CLK_PER_TICK clocks.
//   clk   : system clock
//   reset : async active-high reset (counter loads CLK_PER_TICK-1)
//   tick  : high for the one cycle in which the counter sits at 0
module led_tick_gen #(
  parameter int CLK_PER_TICK = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_PER_TICK - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == '0);
    tick_cnt_d = tick ? RELOAD : tick_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= RELOAD;
    else       tick_cnt_q <= tick_cnt_d;
  end
endmodule

// File: rtl/led_pwm_blinker.sv
// LED output stage behind the PIO: global PWM dimming plus per-LED blinking,
// configured over a small Avalon-MM slave.
//   clk, reset          : system clock, async active-high reset
//   led_in              : raw pattern from the PIO
//   address, chipselect,
//   write_n, writedata  : Avalon-MM write port
//   readdata            : combinational readback of the addressed register
//   led_out             : registered LED pin drive
module led_pwm_blinker
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS     = 10,
  parameter int CLK_PER_TICK = 50000,
  parameter int PERIOD_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);
  logic [PWM_W-1:0]    bright_q, bright_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;

  logic tick, wr_en, wr_period, pwm_on;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  led_tick_gen #(.CLK_PER_TICK(CLK_PER_TICK)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    wr_en     = chipselect && !write_n;
    wr_period = wr_en && (address == ADDR_PERIOD);

    bright_d = bright_q;
    period_d = period_q;
    mask_d   = mask_q;
    if (wr_en && address == ADDR_BRIGHT) bright_d = writedata[PWM_W-1:0];
    if (wr_period)                       period_d = writedata[PERIOD_W-1:0];
    if (wr_en && address == ADDR_MASK)   mask_d   = writedata[NUM_LEDS-1:0];

    pwm_cnt_d = pwm_cnt_q + 1'b1;
    // FF is special-cased so full brightness never has a dark slot.
    pwm_on = (bright_q == BRIGHT_RESET) || (pwm_cnt_q < bright_q);

    // A PERIOD write restarts the blink cycle and overrides any tick/toggle.
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_period || period_q == '0) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == period_q - PERIOD_W'(1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    led_out_d = led_in & {NUM_LEDS{pwm_on}} & (~mask_q | {NUM_LEDS{blink_phase_q}});

    readdata = '0;
    case (address)
      ADDR_BRIGHT: readdata[PWM_W-1:0]    = bright_q;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_MASK:   readdata[NUM_LEDS-1:0] = mask_q;
      default: begin
        readdata[0]    = blink_phase_q;
        readdata[15:8] = pwm_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_q      <= BRIGHT_RESET;
      period_q      <= '0;
      mask_q        <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      led_out_q     <= '0;
    end else begin
      bright_q      <= bright_d;
      period_q      <= period_d;
      mask_q        <= mask_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;
endmodule

// File: tb/tb_led_pwm_blinker.sv
// Directed bench for led_pwm_blinker with a 4-clock tick.
module tb_led_pwm_blinker;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  led_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  led_out;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  led_pwm_blinker #(.NUM_LEDS(10), .CLK_PER_TICK(4), .PERIOD_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .led_in    (led_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; ticks are consumed on edges where cyc%4==0.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, n, nedge, last_edge;
    logic [7:0] s0, s_exp;
    logic prev_stat, last_led1;

    reset = 1'b1; led_in = 10'h3FF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset state and first output after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_out", 32'(led_out), 32'h0);
    reset = 1'b0;
    #1;
    check("rst_rd_bright", readdata, 32'h0000_00FF);
    step();
    check("first_led_out", 32'(led_out), 32'h3FF);

    // PWM duty 64/256
    led_in = 10'h001;
    wr(2'd0, 32'd64);
    step();
    hi = 0;
    repeat (256) begin step(); hi += int'(led_out[0]); end
    check("duty_64", 32'(hi), 32'd64);
    check("duty_64_others", 32'(led_out[9:1]), 32'h0);

    // pwm_cnt advances by one per clock
    address = 2'd3;
    #1 s0 = readdata[15:8];
    s_exp = s0 + 8'd1;
    step();
    check("pwm_inc", 32'(readdata[15:8]), 32'(s_exp));

    // BRIGHT = 0 -> always dark
    wr(2'd0, 32'd0);
    step();
    hi = 0;
    repeat (256) begin step(); hi += int'(led_out[0]); end
    check("duty_0", 32'(hi), 32'd0);

    // Register readback widths and read-only STATUS
    wr(2'd1, 32'hFFFF_1234);
    address = 2'd1; #1;
    check("rd_period", readdata, 32'h0000_1234);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2; #1;
    check("rd_mask", readdata, 32'h0000_03FF);
    wr(2'd3, 32'hDEAD_BEEF);
    address = 2'd0; #1;
    check("ro_bright", readdata, 32'h0);
    address = 2'd1; #1;
    check("ro_period", readdata, 32'h0);
    address = 2'd2; #1;
    check("ro_mask", readdata, 32'h3FF);

    // Blink: PERIOD=3 ticks of 4 clocks -> 12-clock half period on LED1
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'h002);
    led_in = 10'h003;
    wr(2'd1, 32'd3);
    address = 2'd3;
    #1;
    prev_stat = readdata[0];
    last_led1 = led_out[1];
    nedge = 0; last_edge = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      check("blink_lead", 32'(led_out[1]), 32'(prev_stat));
      check("led0_on", 32'(led_out[0]), 32'h1);
      if (led_out[1] !== last_led1) begin
        if (nedge > 0) check("blink_interval", 32'(cyc - last_edge), 32'd12);
        last_edge = cyc;
        nedge++;
        last_led1 = led_out[1];
      end
      prev_stat = readdata[0];
    end
    check("blink_edges", 32'(nedge >= 3), 32'h1);

    // PERIOD write on a tick edge while phase=0
    n = 0;
    while (readdata[0] !== 1'b0 && n < 40) begin step(); n++; end
    check("wait_phase0", 32'(readdata[0]), 32'h0);
    n = 0;
    while ((cyc % 4) != 3 && n < 8) begin step(); n++; end
    check("tick_align", 32'(cyc % 4), 32'd3);
    wr(2'd1, 32'd5);
    address = 2'd3; #1;
    check("wr_period_phase", 32'(readdata[0]), 32'h1);
    repeat (19) step();
    check("period5_hold", 32'(readdata[0]), 32'h1);
    step();
    check("period5_toggle", 32'(readdata[0]), 32'h0);

    // Async reset mid-operation
    wr(2'd0, 32'h80);
    wr(2'd2, 32'h3FF);
    led_in = 10'h3FF;
    wr(2'd1, 32'd2);
    repeat (30) step();
    reset = 1'b1;
    #1;
    check("midrst_led_out", 32'(led_out), 32'h0);
    address = 2'd0; #1;
    check("midrst_bright", readdata, 32'hFF);
    address = 2'd1; #1;
    check("midrst_period", readdata, 32'h0);
    address = 2'd2; #1;
    check("midrst_mask", readdata, 32'h0);
    step();
    check("midrst_led_hold", 32'(led_out), 32'h0);
    reset = 1'b0;
    address = 2'd3; #1;
    check("midrst_status", readdata, 32'h0000_0001);
    step();
    check("midrst_led_after", 32'(led_out), 32'h3FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
